// File: rtl/ans_delay_generator.sv
// Responder answer-delay generator: counts DelaySet_i ticks after frame end, then raises a held TX start request.
// Latency: DelaySet_i ticks + 2 clocks to TxStartReq_o. The request is held until TxStartAck_i, cancel or reset; a data timeout aborts.
module ans_delay_generator #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] DelaySet_i,
  input  logic [CNT_W-1:0] DataTimeoutSet_i,
  input  logic             AcqSig_i,
  input  logic             p_RxFrameEnd_i,
  input  logic             p_Cancel_i,
  input  logic             TxDataReady_i,
  input  logic             TxStartAck_i,
  output logic             TxStartReq_o,
  output logic             p_Done_o,
  output logic             p_Abort_o,
  output logic             Busy_o,
  output logic [CNT_W-1:0] DelayCnt_o,
  output logic [CNT_W-1:0] AnsDelay_o
);

  typedef enum logic [1:0] {IDLE, WAIT_DELAY, WAIT_DATA, REQ} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ans_q, ans_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;

  logic [CNT_W:0]   limit;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_inc;

  // One extra bit so a large delay plus timeout can never wrap to a small limit.
  assign limit   = {1'b0, DelaySet_i} + {1'b0, DataTimeoutSet_i};
  assign cnt_sat = (cnt_q == CNT_MAX);
  assign cnt_inc = (AcqSig_i && !cnt_sat) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ans_d   = ans_q;
    done_d  = 1'b0;
    abort_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (p_RxFrameEnd_i) state_d = WAIT_DELAY;
      end
      WAIT_DELAY: begin
        cnt_d = cnt_inc;
        if (cnt_q >= DelaySet_i) state_d = TxDataReady_i ? REQ : WAIT_DATA;
      end
      WAIT_DATA: begin
        cnt_d = cnt_inc;
        if (TxDataReady_i) begin
          state_d = REQ;
        end else if (({1'b0, cnt_q} >= limit) || (cnt_sat && limit[CNT_W])) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end
      end
      REQ: begin
        if (TxStartAck_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          ans_d   = cnt_q;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A newer request frame supersedes one still waiting; a raised request is kept.
    if (p_RxFrameEnd_i && (state_q == WAIT_DELAY || state_q == WAIT_DATA)) begin
      state_d = WAIT_DELAY;
      cnt_d   = '0;
      abort_d = 1'b0;
    end

    if (p_Cancel_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      ans_d   = ans_q;
      done_d  = 1'b0;
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ans_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ans_q   <= ans_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign TxStartReq_o = (state_q == REQ);
  assign Busy_o       = (state_q != IDLE);
  assign p_Done_o     = done_q;
  assign p_Abort_o    = abort_q;
  assign DelayCnt_o   = cnt_q;
  assign AnsDelay_o   = ans_q;

endmodule

// File: tb/tb_ans_delay_generator.sv
// Randomized bench for ans_delay_generator: a transaction-level model predicts each response outcome,
// and a monitor checks every Done/Abort pulse against the scoreboard queue.
module tb_ans_delay_generator;

  localparam int NEVER = 100000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] DelaySet_i = '0;
  logic [15:0] DataTimeoutSet_i = '0;
  logic        AcqSig_i = 1'b0;
  logic        p_RxFrameEnd_i = 1'b0;
  logic        p_Cancel_i = 1'b0;
  logic        TxDataReady_i = 1'b0;
  logic        TxStartAck_i = 1'b0;
  logic        TxStartReq_o, p_Done_o, p_Abort_o, Busy_o;
  logic [15:0] DelayCnt_o, AnsDelay_o;

  ans_delay_generator #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .DelaySet_i(DelaySet_i), .DataTimeoutSet_i(DataTimeoutSet_i),
    .AcqSig_i(AcqSig_i), .p_RxFrameEnd_i(p_RxFrameEnd_i), .p_Cancel_i(p_Cancel_i),
    .TxDataReady_i(TxDataReady_i), .TxStartAck_i(TxStartAck_i),
    .TxStartReq_o(TxStartReq_o), .p_Done_o(p_Done_o), .p_Abort_o(p_Abort_o),
    .Busy_o(Busy_o), .DelayCnt_o(DelayCnt_o), .AnsDelay_o(AnsDelay_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        abort;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] prev_cnt = '0;
  logic [15:0] last_ans = '0;

  // Monitor: every Done/Abort pulse must match the oldest predicted outcome.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (p_Done_o || p_Abort_o)) begin
      vectors++;
      if (p_Done_o && p_Abort_o) begin
        miscompares++;
        $display("FAIL pulse_overlap: done=%0b abort=%0b, required exclusive", p_Done_o, p_Abort_o);
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: done=%0b abort=%0b, required none", p_Done_o, p_Abort_o);
      end else begin
        e = sb.pop_front();
        if (e.abort != p_Abort_o) begin
          miscompares++;
          $display("FAIL outcome_kind: got abort=%0b, required abort=%0b", p_Abort_o, e.abort);
        end else if (p_Abort_o && prev_cnt != e.val) begin
          miscompares++;
          $display("FAIL abort_count: counter before abort %0h, required %0h", prev_cnt, e.val);
        end else if (p_Done_o && (AnsDelay_o != e.val || prev_cnt != e.val || Busy_o || TxStartReq_o)) begin
          miscompares++;
          $display("FAIL done_result: ans=%0d cnt=%0d busy=%0b req=%0b, required ans=cnt=%0d busy=0 req=0",
                   AnsDelay_o, prev_cnt, Busy_o, TxStartReq_o, e.val);
        end
      end
    end
    prev_cnt = DelayCnt_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Outcome from the spec's rules: r is the tick count (since the last frame end) at which data becomes ready.
  function automatic exp_t predict(input int d, input int t, input int r_eff);
    exp_t e;
    int   lim;
    lim = d + t;
    if (r_eff <= d) begin
      e.abort = 1'b0; e.val = 16'(d);
    end else if (r_eff <= lim && r_eff <= 65535) begin
      e.abort = 1'b0; e.val = 16'(r_eff);
    end else begin
      e.abort = 1'b1; e.val = (lim > 65535) ? 16'hFFFF : 16'(lim);
    end
    return e;
  endfunction

  task automatic run_txn(input int d, input int t, input int p, input int r, input int rs,
                         input int ackd, input bit req_fe, input int budget);
    exp_t e;
    int   ticks = 0, c = 0, n = 0, tickd_at = -1, rise = -1, ackcnt = 0, r_eff;
    bit   counted, restarted = 0, acked = 0, fin = 0;
    r_eff = (rs > 0 && r <= rs) ? 0 : r;
    e = predict(d, t, r_eff);
    sb.push_back(e);
    if (!e.abort) last_ans = e.val;
    DelaySet_i = 16'(d);
    DataTimeoutSet_i = 16'(t);
    TxDataReady_i = (r == 0);
    @(negedge clk); p_RxFrameEnd_i = 1'b1;
    @(negedge clk); p_RxFrameEnd_i = 1'b0;
    while (!fin && n < budget) begin
      counted = AcqSig_i;
      if (counted) ticks++;
      AcqSig_i = 1'b0;
      p_RxFrameEnd_i = 1'b0;
      if (acked) begin
        TxStartAck_i = 1'b0;
        fin = 1;
      end else if (p_Abort_o) begin
        fin = 1;
      end else begin
        if (counted && ticks == d && tickd_at < 0) tickd_at = n;
        if (counted && r != 0 && ticks == r) TxDataReady_i = 1'b1;
        if (counted && rs > 0 && !restarted && ticks == rs) begin
          p_RxFrameEnd_i = 1'b1;
          ticks = 0; restarted = 1; c = -1; tickd_at = -1;
        end
        if (TxStartReq_o) begin
          if (rise < 0) begin
            rise = n;
            ackcnt = ackd;
            if (d > 0 && r_eff <= d) check("req_rise_latency", 32'(rise - tickd_at), 32'd1);
            if (req_fe) p_RxFrameEnd_i = 1'b1;
          end else if (req_fe && n == rise + 1) begin
            check("req_held_after_frame_end", 32'(TxStartReq_o), 32'd1);
          end
          if (ackcnt == 0) begin
            TxStartAck_i = 1'b1;
            acked = 1;
          end else begin
            ackcnt--;
          end
        end
        c++;
        if ((c % p) == 0 && !p_RxFrameEnd_i) AcqSig_i = 1'b1;
      end
      if (!fin) begin
        @(negedge clk);
        n++;
      end
    end
    if (!fin) begin
      miscompares++;
      $display("FAIL txn_timeout: no Done/Abort after %0d cycles, required one (d=%0d t=%0d r=%0d)", n, d, t, r);
    end
    AcqSig_i = 1'b0; TxDataReady_i = 1'b0; TxStartAck_i = 1'b0; p_RxFrameEnd_i = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic tick_n(input int k);
    repeat (k) begin
      @(negedge clk); AcqSig_i = 1'b1;
      @(negedge clk); AcqSig_i = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic frame_end();
    @(negedge clk); p_RxFrameEnd_i = 1'b1;
    @(negedge clk); p_RxFrameEnd_i = 1'b0;
  endtask

  initial begin
    int d, t, p, r, rs, ackd, sel;
    bit rfe;
    int w;

    repeat (3) @(negedge clk);
    check("reset_outputs", {TxStartReq_o, p_Done_o, p_Abort_o, Busy_o, DelayCnt_o, AnsDelay_o}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_release", {TxStartReq_o, Busy_o, DelayCnt_o}, 32'd0);

    run_txn(10, 5, 4, 0, 0, 1, 1'b0, 2000);     // data ready early
    run_txn(10, 5, 4, NEVER, 0, 0, 1'b0, 2000); // data never ready
    run_txn(0, 10, 4, 7, 0, 2, 1'b0, 2000);     // zero delay, late data
    run_txn(10, 5, 4, 0, 6, 1, 1'b0, 2000);     // restart at counter 6
    run_txn(10, 5, 4, 0, 0, 3, 1'b1, 2000);     // frame end during REQ ignored

    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(0, 20);
      t = $urandom_range(0, 10);
      p = $urandom_range(4, 7);
      sel = $urandom_range(0, 3);
      r = (sel == 0) ? 0 : (sel == 3) ? NEVER : $urandom_range(1, d + t + 4);
      rs = (d >= 3 && $urandom_range(0, 2) == 0) ? $urandom_range(1, d - 1) : 0;
      ackd = $urandom_range(0, 3);
      rfe = (ackd >= 2) && ($urandom_range(0, 1) == 1);
      run_txn(d, t, p, r, rs, ackd, rfe, 2000);
    end

    // Cancel together with frame end while waiting for data.
    DelaySet_i = 16'd2; DataTimeoutSet_i = 16'd50; TxDataReady_i = 1'b0;
    frame_end();
    tick_n(5);
    check("busy_in_wait_data", 32'(Busy_o), 32'd1);
    p_Cancel_i = 1'b1; p_RxFrameEnd_i = 1'b1;
    @(negedge clk); p_Cancel_i = 1'b0; p_RxFrameEnd_i = 1'b0;
    check("cancel_state", {Busy_o, DelayCnt_o, AnsDelay_o}, {15'd0, 1'b0, 16'd0, last_ans});
    repeat (10) @(negedge clk);

    // Cancel while the request is raised.
    DelaySet_i = 16'd1; TxDataReady_i = 1'b1;
    frame_end();
    tick_n(1);
    w = 0;
    while (!TxStartReq_o && w < 50) begin @(negedge clk); w++; end
    check("req_before_cancel", 32'(TxStartReq_o), 32'd1);
    p_Cancel_i = 1'b1;
    @(negedge clk); p_Cancel_i = 1'b0; TxDataReady_i = 1'b0;
    check("req_dropped_on_cancel", {TxStartReq_o, Busy_o}, 32'd0);
    repeat (5) @(negedge clk);

    // Saturation: limit exceeds the counter range, abort must come from the saturated counter.
    run_txn(16'hFFF0, 16'h0100, 1, NEVER, 0, 0, 1'b0, 70000);

    // Asynchronous reset in the middle of WAIT_DELAY.
    DelaySet_i = 16'd10; DataTimeoutSet_i = 16'd5; TxDataReady_i = 1'b1;
    frame_end();
    tick_n(3);
    check("cnt_before_reset", 32'(DelayCnt_o), 32'd3);
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", {TxStartReq_o, p_Done_o, p_Abort_o, Busy_o, DelayCnt_o, AnsDelay_o}, 32'd0);
    @(negedge clk); rst = 1'b1; TxDataReady_i = 1'b0;
    repeat (8) @(negedge clk);
    check("quiet_after_reset", {Busy_o, TxStartReq_o, DelayCnt_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
